// File: rtl/pll_rst_pkg.sv
// PLL supervisor shared types: FSM encoding and counter sizing helpers.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL supervisor: drives PLL reset, filters lock, staggers channel resets.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_FILT      = 256,
  parameter int STAGGER        = 8,
  parameter int MAX_RETRY      = 3,
  localparam int RW = cw(MAX_RETRY + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pll_lock,
  input  logic              sw_rst_req,
  output logic              pll_reset,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic              fail,
  output logic [RW-1:0]     retry_cnt,
  output logic [7:0]        lol_cnt,
  output logic [2:0]        state
);

  localparam int TW = cw(imax(imax(PLL_RST_CYCLES, LOCK_TIMEOUT),
                              imax(LOCK_FILT, STAGGER)));
  localparam int IW = cw(NUM_CH);

  localparam logic [TW-1:0] T_PRC = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LT  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_LF  = TW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] T_ST  = TW'(STAGGER - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'((NUM_CH > 1) ? NUM_CH - 2 : 0);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  state_e          st;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   idx;
  logic            lock_s;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign state = st;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= PLL_RST;
      timer     <= '0;
      idx       <= '0;
      pll_reset <= 1'b1;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      lol_cnt   <= '0;
    end else if (sw_rst_req) begin
      st        <= PLL_RST;
      timer     <= '0;
      idx       <= '0;
      pll_reset <= 1'b1;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      unique case (st)
        PLL_RST: begin
          if (timer == T_PRC) begin
            st        <= WAIT_LOCK;
            timer     <= '0;
            pll_reset <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            st    <= FILTER;
            timer <= '0;
          end else if (timer == T_LT) begin
            timer <= '0;
            if (retry_cnt == R_MAX) begin
              st   <= FAIL;
              fail <= 1'b1;
            end else begin
              st        <= PLL_RST;
              pll_reset <= 1'b1;
              retry_cnt <= retry_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FILTER: begin
          if (!lock_s) begin
            st    <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == T_LF) begin
            timer    <= '0;
            idx      <= '0;
            ch_rst_n <= CH_ONE;
            if (NUM_CH == 1) begin
              st    <= RUN;
              ready <= 1'b1;
            end else begin
              st <= RELEASE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            st        <= PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            ch_rst_n  <= '0;
            ready     <= 1'b0;
            retry_cnt <= '0;
            if (lol_cnt != 8'hFF) lol_cnt <= lol_cnt + 1'b1;
          end else if (st == RELEASE) begin
            if (timer == T_ST) begin
              timer    <= '0;
              idx      <= idx + 1'b1;
              // Thermometer shift keeps lower channels released
              ch_rst_n <= (ch_rst_n << 1) | CH_ONE;
              if (idx == I_LAST) begin
                st    <= RUN;
                ready <= 1'b1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        FAIL: begin
          timer <= timer;
        end
        default: begin
          st        <= PLL_RST;
          timer     <= '0;
          pll_reset <= 1'b1;
          ch_rst_n  <= '0;
          ready     <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: three configurations, one stimulus.
module tb_pll_rst_seq;

  localparam int PRC = 16;
  localparam int LT  = 400;
  localparam int LF  = 256;
  localparam int MR  = 3;

  logic clk = 1'b0;
  logic resetn;
  logic pll_lock;
  logic sw_rst_req;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [2:0][15:0] ch_a;
  logic [2:0]       rdy_a;
  logic [2:0]       prst_a;
  logic [2:0]       fail_a;
  logic [2:0][1:0]  rc_a;
  logic [2:0][7:0]  lc_a;
  logic [2:0][2:0]  st_a;

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int NC = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    localparam int ST = (g == 0) ? 8 : (g == 1) ? 1 : 3;

    logic          prst, rdy, fl;
    logic [NC-1:0] ch;
    logic [1:0]    rc;
    logic [7:0]    lc;
    logic [2:0]    st;

    pll_rst_seq #(
      .NUM_CH(NC), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT),
      .LOCK_FILT(LF), .STAGGER(ST), .MAX_RETRY(MR)
    ) dut (
      .clk(clk), .resetn(resetn), .pll_lock(pll_lock),
      .sw_rst_req(sw_rst_req), .pll_reset(prst), .ch_rst_n(ch),
      .ready(rdy), .fail(fl), .retry_cnt(rc), .lol_cnt(lc),
      .state(st)
    );

    assign ch_a[g]   = 16'(ch);
    assign rdy_a[g]  = rdy;
    assign prst_a[g] = prst;
    assign fail_a[g] = fl;
    assign rc_a[g]   = rc;
    assign lc_a[g]   = lc;
    assign st_a[g]   = st;

    // Model: phase plus the absolute cycle it was entered
    int ph, t0, cm, rm, lm, el;
    bit s1, s2, ls;
    logic [15:0] mch;

    initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        ph = 0; t0 = 0; cm = 0; rm = 0; lm = 0;
        s1 = 0; s2 = 0;
      end else begin
        cm++;
        el = cm - t0;
        ls = s2; s2 = s1; s1 = pll_lock;
        if (sw_rst_req) begin
          ph = 0; t0 = cm; rm = 0;
        end else if (ph == 0) begin
          if (el == PRC) begin ph = 1; t0 = cm; end
        end else if (ph == 1) begin
          if (ls) begin
            ph = 2; t0 = cm;
          end else if (el == LT) begin
            t0 = cm;
            if (rm < MR) begin rm++; ph = 0; end
            else ph = 5;
          end
        end else if (ph == 2) begin
          if (!ls) begin
            ph = 1; t0 = cm;
          end else if (el == LF) begin
            ph = (NC == 1) ? 4 : 3; t0 = cm;
          end
        end else if (ph == 3 || ph == 4) begin
          if (!ls) begin
            if (lm < 255) lm++;
            rm = 0; ph = 0; t0 = cm;
          end else if (ph == 3 && el == (NC - 1) * ST) begin
            ph = 4; t0 = cm;
          end
        end
      end
      mch = '0;
      for (int k = 0; k < NC; k++)
        if (ph == 4 || (ph == 3 && k * ST <= cm - t0)) mch[k] = 1'b1;
      #1;
      chk($sformatf("u%0d.pll_reset", g), 64'(prst), 64'(ph == 0));
      chk($sformatf("u%0d.ch_rst_n", g), 64'(ch), 64'(mch[NC-1:0]));
      chk($sformatf("u%0d.ready", g), 64'(rdy), 64'(ph == 4));
      chk($sformatf("u%0d.fail", g), 64'(fl), 64'(ph == 5));
      chk($sformatf("u%0d.retry_cnt", g), 64'(rc), 64'(rm));
      chk($sformatf("u%0d.lol_cnt", g), 64'(lc), 64'(lm));
      chk($sformatf("u%0d.state", g), 64'(st), 64'(ph));
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_rdy(input int i, input int lim, input string nm);
    int k = 0;
    while (!rdy_a[i] && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(rdy_a[i]), 64'd1);
  endtask

  task automatic pulse_sw(output int e);
    e = cyc + 1;
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  int e, m;

  initial begin
    resetn = 1'b0;
    pll_lock = 1'b1;
    sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pll_reset", 64'(prst_a[0]), 64'd1);
    chk("rst.ch_rst_n", 64'(ch_a[0]), 64'd0);
    chk("rst.state", 64'(st_a[0]), 64'd0);
    chk("rst.ready", 64'(rdy_a[0]), 64'd0);
    resetn = 1'b1;

    // Cold start with lock already high
    wait_cyc(15);  chk("cold.prst15", 64'(prst_a[0]), 64'd1);
    wait_cyc(16);  chk("cold.prst16", 64'(prst_a[0]), 64'd0);
    chk("cold.wait", 64'(st_a[0]), 64'd1);
    wait_cyc(17);  chk("cold.filter", 64'(st_a[0]), 64'd2);
    wait_cyc(272); chk("cold.ch272", 64'(ch_a[0]), 64'h0);
    wait_cyc(273); chk("cold.ch273", 64'(ch_a[0]), 64'h1);
    chk("cold.nc1_ready", 64'(rdy_a[1]), 64'd1);
    wait_cyc(276); chk("cold.nc16_ch", 64'(ch_a[2]), 64'h3);
    wait_cyc(281); chk("cold.ch281", 64'(ch_a[0]), 64'h3);
    wait_cyc(289); chk("cold.ch289", 64'(ch_a[0]), 64'h7);
    wait_cyc(296); chk("cold.rdy296", 64'(rdy_a[0]), 64'd0);
    wait_cyc(297); chk("cold.ch297", 64'(ch_a[0]), 64'hF);
    chk("cold.rdy297", 64'(rdy_a[0]), 64'd1);
    wait_cyc(317); chk("cold.nc16_rdy317", 64'(rdy_a[2]), 64'd0);
    wait_cyc(318); chk("cold.nc16_rdy318", 64'(rdy_a[2]), 64'd1);
    chk("cold.nc16_ch", 64'(ch_a[2]), 64'hFFFF);

    // Loss of lock in RUN
    wait_cyc(340); pll_lock = 1'b0;
    wait_cyc(342); chk("lol.rdy342", 64'(rdy_a[0]), 64'd1);
    wait_cyc(343);
    chk("lol.ch", 64'(ch_a[0]), 64'h0);
    chk("lol.ready", 64'(rdy_a[0]), 64'd0);
    chk("lol.prst", 64'(prst_a[0]), 64'd1);
    chk("lol.cnt", 64'(lc_a[0]), 64'd1);
    wait_cyc(345); pll_lock = 1'b1;
    wait_rdy(2, 500, "lol.rerun");

    // One-cycle lock glitch inside FILTER
    pulse_sw(e);
    wait_cyc(e + 117); pll_lock = 1'b0;
    wait_cyc(e + 118); pll_lock = 1'b1;
    wait_cyc(e + 120); chk("glitch.wait", 64'(st_a[0]), 64'd1);
    wait_cyc(e + 376); chk("glitch.ch376", 64'(ch_a[0]), 64'h0);
    wait_cyc(e + 377); chk("glitch.ch377", 64'(ch_a[0]), 64'h1);
    chk("glitch.lol", 64'(lc_a[0]), 64'd1);
    wait_rdy(2, 500, "glitch.ready");

    // sw_rst_req coincides with lock loss seen in RUN
    m = cyc;
    pll_lock = 1'b0;
    wait_cyc(m + 2); sw_rst_req = 1'b1;
    wait_cyc(m + 3); sw_rst_req = 1'b0;
    chk("simul.state", 64'(st_a[0]), 64'd0);
    chk("simul.lol", 64'(lc_a[0]), 64'd1);
    chk("simul.ch", 64'(ch_a[0]), 64'h0);
    pll_lock = 1'b1;
    wait_rdy(2, 500, "simul.ready");

    // Lock timeout, retries, failure, software restart
    pll_lock = 1'b0;
    pulse_sw(e);
    wait_cyc(e + 416); chk("to.retry1", 64'(rc_a[0]), 64'd1);
    chk("to.prst", 64'(prst_a[0]), 64'd1);
    wait_cyc(e + 1663); chk("to.retry3", 64'(rc_a[0]), 64'd3);
    chk("to.nofail", 64'(fail_a[0]), 64'd0);
    wait_cyc(e + 1664); chk("to.fail", 64'(fail_a[0]), 64'd1);
    chk("to.state", 64'(st_a[0]), 64'd5);
    chk("to.prst_low", 64'(prst_a[0]), 64'd0);
    wait_cyc(e + 1690); chk("to.hold", 64'(fail_a[0]), 64'd1);
    pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    pulse_sw(e);
    chk("to.clear_fail", 64'(fail_a[0]), 64'd0);
    chk("to.clear_retry", 64'(rc_a[0]), 64'd0);
    wait_rdy(0, 500, "to.recover");

    // Asynchronous reset in the middle of RELEASE
    pulse_sw(e);
    wait_cyc(e + 283); chk("mid.ch", 64'(ch_a[0]), 64'h3);
    resetn = 1'b0;
    #1;
    chk("mid.prst", 64'(prst_a[0]), 64'd1);
    chk("mid.ch0", 64'(ch_a[0]), 64'h0);
    chk("mid.ch2", 64'(ch_a[2]), 64'h0);
    chk("mid.state", 64'(st_a[0]), 64'd0);
    chk("mid.lol", 64'(lc_a[0]), 64'd0);
    chk("mid.ready", 64'(rdy_a[0]), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    wait_cyc(297); chk("rest.rdy", 64'(rdy_a[0]), 64'd1);
    chk("rest.ch", 64'(ch_a[0]), 64'hF);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
